btb_port_arbiter: RTL and testbench
===================================

Name: btb_port_arbiter

Overview:
- Schedules the single-ported BTB array between IF-stage lookups and EX-stage BTB updates.
- Updates come from the misprediction checker (load_btb, br_en, alu_out) and are buffered in a small FIFO.
- Pending updates drain into the array on cycles when IF does not need the port. A drain is forced when the FIFO is full or an entry has waited too long.
- Sits between the IF PC logic, the EX branch-check logic and the BTB storage.

Parameters:
- IDX_W, 5, BTB index width; the array has 2^IDX_W entries.
- Q_DEPTH, 4, update FIFO depth; must be a power of two, at least 2.
- STARVE_MAX, 8, cycles a non-empty FIFO may go without a write before a write is forced.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lkup_req  in  1  IF requests a BTB read this cycle
- lkup_idx  in  IDX_W  read index
- lkup_gnt  out  1  read issued to the array this cycle
- if_stall  out  1  lkup_req && !lkup_gnt
- lkup_valid  out  1  read data valid (one cycle after grant)
- lkup_target  out  32  predicted target
- lkup_taken  out  1  predicted taken bit
- upd_valid  in  1  update request (load_btb)
- upd_idx  in  IDX_W  update index
- upd_target  in  32  resolved target (alu_out)
- upd_taken  in  1  resolved direction (br_en)
- upd_rdy  out  1  FIFO can accept; equals q_count != Q_DEPTH
- arr_en  out  1  array access enable
- arr_we  out  1  1 = write, 0 = read
- arr_idx  out  IDX_W  array index
- arr_wdata  out  33  {taken, target}
- arr_rdata  in  33  {taken, target}; synchronous read, valid the cycle after a read
- q_count  out  $clog2(Q_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, q_count=0, starvation counter=0.
  - lkup_valid=0, lkup_target=0, lkup_taken=0, arr_en=0, arr_we=0.
  - Reset mid-drain discards all queued updates.
- Port decision is combinational each cycle, in priority order:
  1. FORCE: q_count==Q_DEPTH or starve_cnt==STARVE_MAX → write FIFO head.
  2. READ: lkup_req → read lkup_idx, lkup_gnt=1.
  3. IDLE_DRAIN: q_count!=0 → write FIFO head.
  4. Otherwise arr_en=0.
- Write cycle: arr_en=1, arr_we=1, arr_idx/arr_wdata from FIFO head. The head pops at the clock edge.
- Read cycle: arr_en=1, arr_we=0, arr_idx=lkup_idx. lkup_valid rises the next cycle, carrying arr_rdata. lkup_valid is 0 otherwise.
- Enqueue: on upd_valid && upd_rdy. upd_valid while !upd_rdy is illegal; the bench asserts on it and the RTL drops the update.
- Simultaneous enqueue and pop: q_count is unchanged. Pointers wrap modulo Q_DEPTH.
- The FIFO keeps strict order, so a later update to the same index wins.
- Starvation counter:
  - Clears on any write or when q_count==0.
  - Otherwise increments while the FIFO is non-empty and no write occurs.
  - Saturates at STARVE_MAX.
- Pipeline flush does not touch this block; resolved updates are never discarded.

Optional Feature:
- Macro BTB_LKUP_FWD_EN.
- Defined:
  - On a granted read, lkup_idx is compared against all valid FIFO entries, including an enqueue arriving the same cycle.
  - The youngest match is registered and, in the next cycle, overrides arr_rdata on lkup_target/lkup_taken.
  - If the matching entry is the one written that cycle, the array data and the forwarded data are identical anyway.
- Undefined:
  - No comparison logic; lookups return stale array contents until the drain completes.

Decomposition:
- rv32i_types gains btb_entry_t (packed: taken, target[31:0]) and btb_upd_t (idx, btb_entry_t).
- One sub-module is natural: btb_upd_fifo (parameterised sync FIFO with head output and occupancy). It exposes an entry-array view for forwarding when BTB_LKUP_FWD_EN is defined.
- Arbitration, the starvation counter and the read-data register live in the top.

Test Plan:
- Reset release, lkup_req=1 idx=3 with arr_rdata={1,0x100} → lkup_gnt=1 at cycle 0; cycle 1 lkup_valid=1, lkup_target=0x100, lkup_taken=1.
- 4 updates (idx 1..4) with lkup_req held at 1 → q_count reaches 4. Next cycle FORCE write of idx 1, lkup_gnt=0, if_stall=1, upd_rdy=0 that cycle only.
- One update, lkup_req=1 continuously → exactly STARVE_MAX=8 reads granted, then one forced write, starve_cnt back to 0.
- Enqueue and idle-drain in the same cycle with q_count=2 → q_count stays 2; written order matches enqueue order across pointer wrap.
- BTB_LKUP_FWD_EN: queue idx 5 → target 0x200 then idx 5 → 0x300, read idx 5 → lkup_target=0x300, taken from the second update.
- Assert rst_n low while q_count=3 mid-write → all outputs at reset values immediately; after release no writes issue.

Source files
------------

// File: rtl/btb_port_arbiter_pkg.sv
// Shared BTB record types for the port arbiter and its update FIFO.
// btb_entry_t matches the array word layout {taken, target}.
package btb_port_arbiter_pkg;

    localparam int BTB_IDX_W = 5;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } btb_entry_t;

    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        btb_entry_t           entry;
    } btb_upd_t;

endpackage

// File: rtl/btb_port_arbiter_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO holding resolved BTB updates in strict order.
// Exposes the head entry and occupancy; with BTB_LKUP_FWD_EN defined it also
// exposes the raw storage and read pointer so lookups can search pending updates.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
`ifdef BTB_LKUP_FWD_EN
    ,
    output logic [W-1:0]             entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] head_ptr
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is dropped; a pop from an empty one is ignored.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

`ifdef BTB_LKUP_FWD_EN
    assign entries  = mem;
    assign head_ptr = rd_ptr;
`endif

    // Storage has no reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/btb_port_arbiter.sv
// btb_port_arbiter: shares the single-ported BTB array between IF lookups and
// buffered EX updates. Priority is forced drain, then lookup, then idle drain.
// Optional macro BTB_LKUP_FWD_EN forwards pending FIFO updates to lookups.
module btb_port_arbiter
    import btb_port_arbiter_pkg::*;
#(
    parameter int IDX_W      = BTB_IDX_W,
    parameter int Q_DEPTH    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lkup_req,
    input  logic [IDX_W-1:0]           lkup_idx,
    output logic                       lkup_gnt,
    output logic                       if_stall,
    output logic                       lkup_valid,
    output logic [31:0]                lkup_target,
    output logic                       lkup_taken,
    input  logic                       upd_valid,
    input  logic [IDX_W-1:0]           upd_idx,
    input  logic [31:0]                upd_target,
    input  logic                       upd_taken,
    output logic                       upd_rdy,
    output logic                       arr_en,
    output logic                       arr_we,
    output logic [IDX_W-1:0]           arr_idx,
    output logic [32:0]                arr_wdata,
    input  logic [32:0]                arr_rdata,
    output logic [$clog2(Q_DEPTH):0]   q_count
);

    localparam int UW = IDX_W + 33;
    localparam int CW = $clog2(Q_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [UW-1:0]    head;
    logic [IDX_W-1:0] head_idx;
    btb_entry_t       head_entry;
    btb_entry_t       upd_entry;
    logic             q_empty;
    logic             q_full;
    logic             force_wr;
    logic             do_write;
    logic             do_read;
    logic [SW-1:0]    starve_cnt;
    btb_entry_t       rd_entry;

    assign upd_entry              = '{taken: upd_taken, target: upd_target};
    assign {head_idx, head_entry} = head;
    assign q_empty                = (q_count == '0);
    assign q_full                 = (q_count == CW'(Q_DEPTH));
    assign force_wr               = !q_empty && (q_full || starve_cnt == SW'(STARVE_MAX));

`ifdef BTB_LKUP_FWD_EN
    localparam int PW = $clog2(Q_DEPTH);

    logic [UW-1:0] q_entries [Q_DEPTH];
    logic [PW-1:0] q_head_ptr;
    logic [PW-1:0] slot;
    logic          fwd_hit_c;
    btb_entry_t    fwd_entry_c;
    logic          fwd_hit;
    btb_entry_t    fwd_entry;
`endif

    btb_upd_fifo #(
        .DEPTH (Q_DEPTH),
        .W     (UW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (upd_valid),
        .push_data ({upd_idx, upd_entry}),
        .pop       (do_write),
        .head      (head),
        .count     (q_count)
`ifdef BTB_LKUP_FWD_EN
        ,
        .entries   (q_entries),
        .head_ptr  (q_head_ptr)
`endif
    );

    // Port decision: forced drain beats lookups, lookups beat opportunistic drain.
    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        if (!rst_n) begin
            do_write = 1'b0;
        end else if (force_wr) begin
            do_write = 1'b1;
        end else if (lkup_req) begin
            do_read = 1'b1;
        end else if (!q_empty) begin
            do_write = 1'b1;
        end
    end

    assign lkup_gnt  = do_read;
    assign if_stall  = lkup_req && !lkup_gnt;
    assign upd_rdy   = !q_full;
    assign arr_en    = do_read || do_write;
    assign arr_we    = do_write;
    assign arr_idx   = do_write ? head_idx : lkup_idx;
    assign arr_wdata = head_entry;

    // Counts cycles a pending update is denied the port; any write or empty FIFO clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (do_write || q_empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Read data returns the cycle after a granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkup_valid <= 1'b0;
        end else begin
            lkup_valid <= do_read;
        end
    end

`ifdef BTB_LKUP_FWD_EN
    // Search pending updates oldest to youngest so the youngest match wins; a same-cycle enqueue is youngest.
    always_comb begin
        fwd_hit_c   = 1'b0;
        fwd_entry_c = '0;
        slot        = '0;
        for (int k = 0; k < Q_DEPTH; k++) begin
            slot = q_head_ptr + PW'(k);
            if (CW'(k) < q_count && q_entries[slot][UW-1 -: IDX_W] == lkup_idx) begin
                fwd_hit_c   = 1'b1;
                fwd_entry_c = btb_entry_t'(q_entries[slot][32:0]);
            end
        end
        if (upd_valid && upd_rdy && upd_idx == lkup_idx) begin
            fwd_hit_c   = 1'b1;
            fwd_entry_c = upd_entry;
        end
    end

    // Capture the forwarded entry alongside the array read it will override.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit   <= 1'b0;
            fwd_entry <= '0;
        end else begin
            fwd_hit   <= do_read && fwd_hit_c;
            fwd_entry <= fwd_entry_c;
        end
    end

    // Forwarded data takes precedence over the possibly stale array word.
    always_comb begin
        rd_entry = btb_entry_t'(arr_rdata);
        if (fwd_hit) begin
            rd_entry = fwd_entry;
        end
    end
`else
    // Without forwarding the array word is returned as-is.
    always_comb begin
        rd_entry = btb_entry_t'(arr_rdata);
    end
`endif

    assign lkup_target = lkup_valid ? rd_entry.target : 32'h0;
    assign lkup_taken  = lkup_valid ? rd_entry.taken  : 1'b0;

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Directed testbench for btb_port_arbiter with a behavioural single-port BTB array.
// Set BTB_LKUP_FWD_EN to expect forwarded lookup data.
module tb_btb_port_arbiter;

    localparam int IDX_W      = 5;
    localparam int Q_DEPTH    = 4;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              rst_n;
    logic              lkup_req;
    logic [IDX_W-1:0]  lkup_idx;
    logic              lkup_gnt;
    logic              if_stall;
    logic              lkup_valid;
    logic [31:0]       lkup_target;
    logic              lkup_taken;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic [31:0]       upd_target;
    logic              upd_taken;
    logic              upd_rdy;
    logic              arr_en;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [32:0]       arr_wdata;
    logic [32:0]       arr_rdata = '0;
    logic [2:0]        q_count;

    logic [32:0]       mem [32];

    int vecCount  = 0;
    int missCount = 0;

    btb_port_arbiter #(
        .IDX_W      (IDX_W),
        .Q_DEPTH    (Q_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lkup_req    (lkup_req),
        .lkup_idx    (lkup_idx),
        .lkup_gnt    (lkup_gnt),
        .if_stall    (if_stall),
        .lkup_valid  (lkup_valid),
        .lkup_target (lkup_target),
        .lkup_taken  (lkup_taken),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_rdy     (upd_rdy),
        .arr_en      (arr_en),
        .arr_we      (arr_we),
        .arr_idx     (arr_idx),
        .arr_wdata   (arr_wdata),
        .arr_rdata   (arr_rdata),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port array: synchronous write, registered read.
    always @(posedge clk) begin
        if (arr_en && arr_we) begin
            mem[arr_idx] <= arr_wdata;
        end
        if (arr_en && !arr_we) begin
            arr_rdata <= mem[arr_idx];
        end
    end

    // Enqueueing into a full FIFO is illegal for the producer.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(upd_valid && !upd_rdy)) else $error("[TB] illegal enqueue while upd_rdy=0");
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next cycle, drive that cycle's inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic req, input logic [IDX_W-1:0] idx, input logic uv,
                                 input logic [IDX_W-1:0] uidx, input logic [31:0] utgt, input logic utk);
        @(posedge clk);
        #1;
        lkup_req   = req;
        lkup_idx   = idx;
        upd_valid  = uv;
        upd_idx    = uidx;
        upd_target = utgt;
        upd_taken  = utk;
        #1;
    endtask

    initial begin
        int reads;
        logic wrote;
        logic [31:0] exp_tgt5;
        logic        exp_tk5;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[3] = {1'b1, 32'h100};
        mem[5] = {1'b0, 32'h555};

        rst_n = 1'b0; lkup_req = 1'b0; lkup_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_target = '0; upd_taken = 1'b0;
        #12;
        $display("[TB] reset values");
        checkOutput("rst_q_count", q_count, 0);
        checkOutput("rst_lkup_valid", lkup_valid, 0);
        checkOutput("rst_lkup_target", lkup_target, 0);
        checkOutput("rst_lkup_taken", lkup_taken, 0);
        checkOutput("rst_arr_en", arr_en, 0);
        checkOutput("rst_arr_we", arr_we, 0);
        checkOutput("rst_upd_rdy", upd_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] first lookup after reset");
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("c0_gnt", lkup_gnt, 1);
        checkOutput("c0_arr_en", arr_en, 1);
        checkOutput("c0_arr_we", arr_we, 0);
        checkOutput("c0_arr_idx", arr_idx, 3);
        checkOutput("c0_if_stall", if_stall, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("c1_valid", lkup_valid, 1);
        checkOutput("c1_target", lkup_target, 32'h100);
        checkOutput("c1_taken", lkup_taken, 1);
        checkOutput("c1_arr_en", arr_en, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("c2_valid", lkup_valid, 0);

        $display("[TB] fill FIFO under continuous lookups");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 7, 1, IDX_W'(i), 32'h10 * i, i[0]);
            checkOutput("fill_q_count", q_count, i - 1);
            checkOutput("fill_gnt", lkup_gnt, 1);
        end
        applyStimulus(1, 7, 0, 0, 0, 0);
        checkOutput("full_q_count", q_count, 4);
        checkOutput("full_upd_rdy", upd_rdy, 0);
        checkOutput("full_gnt", lkup_gnt, 0);
        checkOutput("full_if_stall", if_stall, 1);
        checkOutput("full_arr_we", arr_we, 1);
        checkOutput("full_arr_idx", arr_idx, 1);
        checkOutput("full_arr_wdata", arr_wdata, {1'b1, 32'h10});
        applyStimulus(1, 7, 0, 0, 0, 0);
        checkOutput("post_force_q", q_count, 3);
        checkOutput("post_force_rdy", upd_rdy, 1);
        checkOutput("post_force_gnt", lkup_gnt, 1);
        checkOutput("post_force_stall", if_stall, 0);
        for (int j = 2; j <= 4; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("drain_we", arr_we, 1);
            checkOutput("drain_idx", arr_idx, j);
            checkOutput("drain_wdata", arr_wdata, {j[0], 32'h10 * j});
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drained_q", q_count, 0);
        checkOutput("drained_en", arr_en, 0);

        $display("[TB] starvation forcing");
        applyStimulus(1, 2, 1, 9, 32'h900, 1);
        checkOutput("starve_enq_gnt", lkup_gnt, 1);
        reads = 0;
        wrote = 1'b0;
        for (int c = 0; c < 20 && !wrote; c++) begin
            applyStimulus(1, 2, 0, 0, 0, 0);
            if (arr_we) begin
                wrote = 1'b1;
                checkOutput("starve_wr_idx", arr_idx, 9);
                checkOutput("starve_wr_stall", if_stall, 1);
            end else if (lkup_gnt) begin
                reads++;
            end
        end
        checkOutput("starve_forced", wrote, 1);
        checkOutput("starve_reads", reads, STARVE_MAX);
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("starve_clr", dut.starve_cnt, 0);
        checkOutput("starve_q", q_count, 0);
        checkOutput("starve_gnt", lkup_gnt, 1);

        $display("[TB] enqueue with idle drain across pointer wrap");
        applyStimulus(1, 0, 1, 10, 32'hA00, 0);
        applyStimulus(1, 0, 1, 11, 32'hB00, 1);
        checkOutput("wrap_q1", q_count, 1);
        for (int k = 12; k <= 14; k++) begin
            applyStimulus(0, 0, 1, IDX_W'(k), 32'h100 * k, k[0]);
            checkOutput("wrap_q_steady", q_count, 2);
            checkOutput("wrap_we", arr_we, 1);
            checkOutput("wrap_idx", arr_idx, k - 2);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_q_after", q_count, 2);
        checkOutput("wrap_idx13", arr_idx, 13);
        checkOutput("wrap_wdata13", arr_wdata, {1'b1, 32'hD00});
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_idx14", arr_idx, 14);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_empty", q_count, 0);
        checkOutput("wrap_mem12", mem[12], {1'b0, 32'hC00});

        $display("[TB] lookup of an index with pending updates");
`ifdef BTB_LKUP_FWD_EN
        exp_tgt5 = 32'h300;
        exp_tk5  = 1'b1;
`else
        exp_tgt5 = 32'h555;
        exp_tk5  = 1'b0;
`endif
        applyStimulus(1, 0, 1, 5, 32'h200, 0);
        applyStimulus(1, 5, 1, 5, 32'h300, 1);
        checkOutput("fwd_gnt", lkup_gnt, 1);
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("fwd_q", q_count, 2);
        checkOutput("fwd_valid", lkup_valid, 1);
        checkOutput("fwd_target_a", lkup_target, exp_tgt5);
        checkOutput("fwd_taken_a", lkup_taken, exp_tk5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fwd_target_b", lkup_target, exp_tgt5);
        checkOutput("fwd_drain_idx", arr_idx, 5);
        checkOutput("fwd_drain_wdata", arr_wdata, {1'b0, 32'h200});
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fwd_drain2_wdata", arr_wdata, {1'b1, 32'h300});
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("fwd_final_q", q_count, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("order_target", lkup_target, 32'h300);
        checkOutput("order_taken", lkup_taken, 1);

        $display("[TB] reset during drain");
        applyStimulus(1, 0, 1, 20, 32'h2000, 1);
        applyStimulus(1, 0, 1, 21, 32'h2100, 1);
        applyStimulus(1, 0, 1, 22, 32'h2200, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("mid_q", q_count, 3);
        checkOutput("mid_we", arr_we, 1);
        checkOutput("mid_idx", arr_idx, 20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_q", q_count, 0);
        checkOutput("arst_en", arr_en, 0);
        checkOutput("arst_we", arr_we, 0);
        checkOutput("arst_valid", lkup_valid, 0);
        checkOutput("arst_target", lkup_target, 0);
        checkOutput("arst_taken", lkup_taken, 0);
        checkOutput("arst_rdy", upd_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("post_rst_en", arr_en, 0);
            checkOutput("post_rst_q", q_count, 0);
        end
        checkOutput("post_rst_mem20", mem[20], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
